// File: rtl/ans_ht_stf_detector.sv
// HT-STF detector: sliding delay-16 autocorrelation against window power.
// The plateau is qualified against a fraction of the power and reported as detect/end pulses.
module ans_ht_stf_detector #(
    parameter int unsigned THRESH_SHIFT = 2,
    parameter int unsigned MIN_POWER    = 256,
    parameter int unsigned MIN_PLATEAU  = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [31:0] sample_in,
    input  logic        sample_in_strobe,
    output logic        metric_valid,
    output logic [20:0] corr_mag,
    output logic [20:0] corr_pwr,
    output logic        ht_stf_active,
    output logic        ht_stf_detected,
    output logic        ht_stf_end
);
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned PW        = 17;
    localparam int unsigned AW        = 21;
    localparam int unsigned PCW       = $clog2(MIN_PLATEAU + 1);
    localparam int unsigned FILL_LAST = 31;

    typedef enum logic [1:0] {ST_FILL, ST_SEARCH, ST_PLATEAU, ST_DETECTED} state_e;

    // Stage 0: sample capture
    logic        v0_q, v0_d;
    logic [31:0] s0_q, s0_d;

    always_comb begin
        v0_d = enable & sample_in_strobe;
        s0_d = (enable && sample_in_strobe) ? sample_in : s0_q;
        if (!enable) s0_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v0_q <= 1'b0;
            s0_q <= '0;
        end else begin
            v0_q <= v0_d;
            s0_q <= s0_d;
        end
    end

    // Stage 1: delay line and per-sample products, scaled by 2^-16
    logic [DEPTH-1:0][31:0]  dl_q, dl_d;
    logic                    v1_q, v1_d;
    logic signed [PW-1:0]    re1_q, re1_d, im1_q, im1_d;
    logic [PW-1:0]           p1_q, p1_d;
    logic signed [15:0]      si, sq, di, dq;
    logic signed [31:0]      m_ii, m_qq, m_qi, m_iq, m_pi, m_pq;
    logic signed [32:0]      sum_re, sum_im, sum_p;

    always_comb begin
        si     = $signed(s0_q[31:16]);
        sq     = $signed(s0_q[15:0]);
        di     = $signed(dl_q[DEPTH-1][31:16]);
        dq     = $signed(dl_q[DEPTH-1][15:0]);
        m_ii   = 32'(si) * 32'(di);
        m_qq   = 32'(sq) * 32'(dq);
        m_qi   = 32'(sq) * 32'(di);
        m_iq   = 32'(si) * 32'(dq);
        m_pi   = 32'(si) * 32'(si);
        m_pq   = 32'(sq) * 32'(sq);
        sum_re = 33'(m_ii) + 33'(m_qq);
        sum_im = 33'(m_qi) - 33'(m_iq);
        sum_p  = 33'(m_pi) + 33'(m_pq);
        re1_d  = 17'(sum_re >>> 16);
        im1_d  = 17'(sum_im >>> 16);
        p1_d   = 17'(sum_p >>> 16);
        v1_d   = v0_q & enable;
        dl_d   = v0_q ? {dl_q[DEPTH-2:0], s0_q} : dl_q;
        if (!enable) begin
            dl_d  = '0;
            re1_d = '0;
            im1_d = '0;
            p1_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dl_q  <= '0;
            v1_q  <= 1'b0;
            re1_q <= '0;
            im1_q <= '0;
            p1_q  <= '0;
        end else begin
            dl_q  <= dl_d;
            v1_q  <= v1_d;
            re1_q <= re1_d;
            im1_q <= im1_d;
            p1_q  <= p1_d;
        end
    end

    // Stage 2: product FIFOs feeding running window sums
    logic [DEPTH-1:0][PW-1:0] fre_q, fre_d, fim_q, fim_d, fp_q, fp_d;
    logic signed [AW-1:0]     acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [AW-1:0]            acc_p_q, acc_p_d;
    logic                     v2_q, v2_d;

    always_comb begin
        fre_d    = fre_q;
        fim_d    = fim_q;
        fp_d     = fp_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        acc_p_d  = acc_p_q;
        v2_d     = v1_q & enable;
        if (v1_q) begin
            fre_d    = {fre_q[DEPTH-2:0], re1_q};
            fim_d    = {fim_q[DEPTH-2:0], im1_q};
            fp_d     = {fp_q[DEPTH-2:0], p1_q};
            acc_re_d = acc_re_q + AW'(re1_q) - AW'($signed(fre_q[DEPTH-1]));
            acc_im_d = acc_im_q + AW'(im1_q) - AW'($signed(fim_q[DEPTH-1]));
            acc_p_d  = acc_p_q + AW'(p1_q) - AW'(fp_q[DEPTH-1]);
        end
        if (!enable) begin
            fre_d    = '0;
            fim_d    = '0;
            fp_d     = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            acc_p_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fre_q    <= '0;
            fim_q    <= '0;
            fp_q     <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            acc_p_q  <= '0;
            v2_q     <= 1'b0;
        end else begin
            fre_q    <= fre_d;
            fim_q    <= fim_d;
            fp_q     <= fp_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            acc_p_q  <= acc_p_d;
            v2_q     <= v2_d;
        end
    end

    // Stage 3: magnitude approximation and plateau qualification
    logic [AW-1:0] abs_re, abs_im, mag_c, thresh_c;
    logic          qualify_c, window_ok_c;
    state_e        state_q, state_d;
    logic [4:0]    fill_q, fill_d;
    logic [PCW-1:0] plat_q, plat_d;

    always_comb begin
        abs_re      = acc_re_q[AW-1] ? AW'(-acc_re_q) : AW'(acc_re_q);
        abs_im      = acc_im_q[AW-1] ? AW'(-acc_im_q) : AW'(acc_im_q);
        mag_c       = (abs_re >= abs_im) ? abs_re + (abs_im >> 1) : abs_im + (abs_re >> 1);
        thresh_c    = acc_p_q - (acc_p_q >> THRESH_SHIFT);
        qualify_c   = (acc_p_q >= AW'(MIN_POWER)) && (mag_c > thresh_c);
        window_ok_c = v2_q && ((state_q != ST_FILL) || (fill_q == 5'(FILL_LAST)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            plat_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            plat_q  <= plat_d;
        end
    end

    // The FILL window closing at index 31 is evaluated exactly like SEARCH
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        plat_d  = plat_q;
        if (!enable) begin
            state_d = ST_FILL;
            fill_d  = '0;
            plat_d  = '0;
        end else if (v2_q) begin
            case (state_q)
                ST_FILL, ST_SEARCH: begin
                    if (state_q == ST_FILL && fill_q != 5'(FILL_LAST)) begin
                        fill_d = fill_q + 5'd1;
                    end else if (qualify_c) begin
                        state_d = (MIN_PLATEAU <= 1) ? ST_DETECTED : ST_PLATEAU;
                        plat_d  = PCW'(1);
                    end else begin
                        state_d = ST_SEARCH;
                        plat_d  = '0;
                    end
                end
                ST_PLATEAU: begin
                    if (!qualify_c) begin
                        state_d = ST_SEARCH;
                        plat_d  = '0;
                    end else if (plat_q >= PCW'(MIN_PLATEAU - 1)) begin
                        state_d = ST_DETECTED;
                        plat_d  = PCW'(MIN_PLATEAU);
                    end else begin
                        plat_d = plat_q + PCW'(1);
                    end
                end
                ST_DETECTED: begin
                    if (!qualify_c) begin
                        state_d = ST_SEARCH;
                        plat_d  = '0;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    logic           metric_valid_q, metric_valid_d;
    logic [AW-1:0]  corr_mag_q, corr_mag_d, corr_pwr_q, corr_pwr_d;
    logic           active_q, active_d, det_q, det_d, end_q, end_d;

    always_comb begin
        metric_valid_d = window_ok_c;
        corr_mag_d     = window_ok_c ? mag_c : corr_mag_q;
        corr_pwr_d     = window_ok_c ? acc_p_q : corr_pwr_q;
        det_d          = window_ok_c && (state_d == ST_DETECTED) && (state_q != ST_DETECTED);
        end_d          = window_ok_c && (state_q == ST_DETECTED) && (state_d != ST_DETECTED);
        active_d       = (state_d == ST_DETECTED);
        if (!enable) begin
            metric_valid_d = 1'b0;
            corr_mag_d     = '0;
            corr_pwr_d     = '0;
            det_d          = 1'b0;
            end_d          = 1'b0;
            active_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            metric_valid_q <= 1'b0;
            corr_mag_q     <= '0;
            corr_pwr_q     <= '0;
            det_q          <= 1'b0;
            end_q          <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            metric_valid_q <= metric_valid_d;
            corr_mag_q     <= corr_mag_d;
            corr_pwr_q     <= corr_pwr_d;
            det_q          <= det_d;
            end_q          <= end_d;
            active_q       <= active_d;
        end
    end

    assign metric_valid    = metric_valid_q;
    assign corr_mag        = corr_mag_q;
    assign corr_pwr        = corr_pwr_q;
    assign ht_stf_detected = det_q;
    assign ht_stf_end      = end_q;
    assign ht_stf_active   = active_q;

endmodule

// File: tb/tb_ans_ht_stf_detector.sv
// Self-checking bench for ans_ht_stf_detector: table of constant bursts plus
// hand-written reset, two-burst, enable-drop and pseudo-random sequences.
module tb_ans_ht_stf_detector;
    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [31:0] sample_in;
    logic        sample_in_strobe;
    logic        metric_valid;
    logic [20:0] corr_mag;
    logic [20:0] corr_pwr;
    logic        ht_stf_active;
    logic        ht_stf_detected;
    logic        ht_stf_end;

    ans_ht_stf_detector dut (
        .clk(clk), .rstn(rstn), .enable(enable),
        .sample_in(sample_in), .sample_in_strobe(sample_in_strobe),
        .metric_valid(metric_valid), .corr_mag(corr_mag), .corr_pwr(corr_pwr),
        .ht_stf_active(ht_stf_active), .ht_stf_detected(ht_stf_detected),
        .ht_stf_end(ht_stf_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] smp [0:511];
    int          strobe_edge [0:511];

    int          met_cyc[$];
    logic [20:0] met_mag[$];
    logic [20:0] met_pwr[$];
    int          det_cyc[$];
    int          end_cyc[$];
    int          both_cnt = 0;

    always @(negedge clk) begin
        if (metric_valid) begin
            met_cyc.push_back(cyc);
            met_mag.push_back(corr_mag);
            met_pwr.push_back(corr_pwr);
        end
        if (ht_stf_detected) det_cyc.push_back(cyc);
        if (ht_stf_end) end_cyc.push_back(cyc);
        if (ht_stf_detected && ht_stf_end) both_cnt++;
    end

    typedef struct {
        logic [15:0] i_val;
        logic [15:0] q_val;
        bit          flip;
        int          gap;
        int          n_const;
        int          n_zero;
        int          exp_det;
        int          exp_end;
        int          exp_mag40;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Direct window sum, independent of any running accumulator
    function automatic void model(input int n, output longint mag, output longint pwr);
        longint ar, ai, ap, i0, q0, i1, q1, a, b;
        ar = 0; ai = 0; ap = 0;
        for (int k = n - 15; k <= n; k++) begin
            i0 = longint'($signed(smp[k][31:16]));
            q0 = longint'($signed(smp[k][15:0]));
            i1 = 0; q1 = 0;
            if (k >= 16) begin
                i1 = longint'($signed(smp[k-16][31:16]));
                q1 = longint'($signed(smp[k-16][15:0]));
            end
            ar += (i0 * i1 + q0 * q1) >>> 16;
            ai += (q0 * i1 - i0 * q1) >>> 16;
            ap += (i0 * i0 + q0 * q0) >>> 16;
        end
        a = (ar < 0) ? -ar : ar;
        b = (ai < 0) ? -ai : ai;
        mag = (a >= b) ? a + (b >> 1) : b + (a >> 1);
        pwr = ap;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_samples(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_in        = smp[i];
            sample_in_strobe = 1'b1;
            strobe_edge[i]   = cyc + 1;
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
                sample_in_strobe = 1'b0;
                sample_in        = 32'hDEAD_BEEF;
            end
        end
        @(negedge clk);
        sample_in_strobe = 1'b0;
    endtask

    task automatic restart(input string tag);
        @(negedge clk);
        enable = 1'b0;
        sample_in_strobe = 1'b0;
        idle(2);
        chk({tag, " clear_flags"}, {metric_valid, ht_stf_detected, ht_stf_end, ht_stf_active}, 0);
        met_cyc.delete(); met_mag.delete(); met_pwr.delete();
        det_cyc.delete(); end_cyc.delete();
        enable = 1'b1;
    endtask

    task automatic check_metrics(input int n_tot, input string tag);
        int bad;
        string det;
        longint m, p;
        bad = 0;
        det = "";
        chk({tag, " metric_count"}, met_mag.size(), n_tot - 31);
        for (int k = 0; k < met_mag.size() && (31 + k) < n_tot; k++) begin
            model(31 + k, m, p);
            if (longint'(met_mag[k]) != m || longint'(met_pwr[k]) != p ||
                met_cyc[k] != strobe_edge[31 + k] + 3) begin
                if (bad == 0)
                    det = $sformatf(" idx%0d mag %0h/%0h pwr %0h/%0h edge %0d/%0d", 31 + k,
                                    met_mag[k], m, met_pwr[k], p, met_cyc[k], strobe_edge[31 + k] + 3);
                bad++;
            end
        end
        chk({tag, " corr_seq", det}, bad, 0);
    endtask

    task automatic build_burst(input int base, input logic [15:0] iv, input logic [15:0] qv,
                               input bit flip, input int n);
        logic signed [15:0] ii, qq;
        for (int i = 0; i < n; i++) begin
            ii = $signed(iv);
            qq = $signed(qv);
            if (flip && ((i / 16) % 2 == 1)) begin
                ii = -ii;
                qq = -qq;
            end
            smp[base + i] = {ii, qq};
        end
    endtask

    task automatic fill_zero(input int base, input int n);
        for (int i = 0; i < n; i++) smp[base + i] = 32'h0;
    endtask

    task automatic run_case(input vec_t v, input int id);
        string  tag;
        int     n;
        longint m40;
        tag = $sformatf("case%0d", id);
        n = v.n_const + v.n_zero;
        restart(tag);
        build_burst(0, v.i_val, v.q_val, v.flip, v.n_const);
        fill_zero(v.n_const, v.n_zero);
        drive_samples(n, v.gap);
        idle(6);
        check_metrics(n, tag);
        m40 = (met_mag.size() > 9) ? longint'(met_mag[9]) : -1;
        chk({tag, " mag_idx40"}, m40, v.exp_mag40);
        chk({tag, " det_count"}, det_cyc.size(), (v.exp_det >= 0) ? 1 : 0);
        if (v.exp_det >= 0 && det_cyc.size() > 0)
            chk({tag, " det_edge"}, det_cyc[0], strobe_edge[v.exp_det] + 3);
        chk({tag, " end_count"}, end_cyc.size(), (v.exp_end >= 0) ? 1 : 0);
        if (v.exp_end >= 0 && end_cyc.size() > 0)
            chk({tag, " end_edge"}, end_cyc[0], strobe_edge[v.exp_end] + 3);
        chk({tag, " active_final"}, ht_stf_active, 0);
    endtask

    initial begin
        logic [31:0] lfsr;
        vecs[0] = '{16'h2000, 16'h0000, 1'b0, 1, 80, 40, 62, 95, 'h4000};
        vecs[1] = '{16'h2000, 16'h0000, 1'b0, 3, 80, 40, 62, 95, 'h4000};
        vecs[2] = '{16'h0000, 16'h2000, 1'b0, 1, 80, 40, 62, 95, 'h4000};
        vecs[3] = '{16'h1000, 16'h1000, 1'b0, 1, 80, 40, 62, 95, 'h2000};
        vecs[4] = '{16'hE000, 16'h0000, 1'b0, 2, 80, 40, 62, 95, 'h4000};
        vecs[5] = '{16'h2000, 16'h0000, 1'b1, 1, 80, 40, 62, 95, 'h4000};
        vecs[6] = '{16'h0400, 16'h0000, 1'b0, 1, 80, 40, 62, 80, 'h0100};
        vecs[7] = '{16'h0300, 16'h0000, 1'b0, 1, 80, 40, -1, -1, 'h0090};
        vecs[8] = '{16'h2000, 16'hE000, 1'b0, 1, 80, 40, 62, 95, 'h8000};

        rstn = 1'b0;
        enable = 1'b0;
        sample_in = '0;
        sample_in_strobe = 1'b0;
        idle(3);
        chk("reset flags", {metric_valid, ht_stf_detected, ht_stf_end, ht_stf_active}, 0);
        chk("reset corr_mag", corr_mag, 0);
        chk("reset corr_pwr", corr_pwr, 0);
        rstn = 1'b1;
        enable = 1'b1;
        idle(2);

        for (int v = 0; v < 9; v++) run_case(vecs[v], v);

        // Asynchronous reset while in the plateau (plat_cnt = 20 after index 50)
        restart("rst");
        build_burst(0, 16'h2000, 16'h0000, 1'b0, 80);
        fill_zero(80, 40);
        drive_samples(51, 1);
        idle(5);
        chk("rst pre_pwr", corr_pwr, 'h4000);
        chk("rst pre_det_count", det_cyc.size(), 0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst async_flags", {metric_valid, ht_stf_detected, ht_stf_end, ht_stf_active}, 0);
        chk("rst async_mag", corr_mag, 0);
        chk("rst async_pwr", corr_pwr, 0);
        idle(2);
        rstn = 1'b1;
        chk("rst no_end", end_cyc.size(), 0);
        met_cyc.delete(); met_mag.delete(); met_pwr.delete();
        det_cyc.delete(); end_cyc.delete();
        drive_samples(120, 1);
        idle(6);
        check_metrics(120, "replay");
        chk("replay det_count", det_cyc.size(), 1);
        if (det_cyc.size() > 0) chk("replay det_edge", det_cyc[0], strobe_edge[62] + 3);
        chk("replay end_count", end_cyc.size(), 1);
        if (end_cyc.size() > 0) chk("replay end_edge", end_cyc[0], strobe_edge[95] + 3);

        // Two bursts separated by 64 zeros
        restart("two");
        build_burst(0, 16'h2000, 16'h0000, 1'b0, 80);
        fill_zero(80, 64);
        build_burst(144, 16'h2000, 16'h0000, 1'b0, 80);
        fill_zero(224, 40);
        drive_samples(264, 1);
        idle(6);
        check_metrics(264, "two");
        chk("two det_count", det_cyc.size(), 2);
        chk("two end_count", end_cyc.size(), 2);
        if (det_cyc.size() == 2 && end_cyc.size() == 2) begin
            chk("two det0_edge", det_cyc[0], strobe_edge[62] + 3);
            chk("two end0_edge", end_cyc[0], strobe_edge[95] + 3);
            chk("two det1_edge", det_cyc[1], strobe_edge[203] + 3);
            chk("two end1_edge", end_cyc[1], strobe_edge[239] + 3);
        end

        // Enable dropped inside the second burst while detected
        restart("en");
        drive_samples(212, 1);
        idle(4);
        chk("en active_before", ht_stf_active, 1);
        chk("en det_count", det_cyc.size(), 2);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("en active_after", ht_stf_active, 0);
        idle(3);
        chk("en flags_after", {metric_valid, ht_stf_detected, ht_stf_end, ht_stf_active}, 0);
        chk("en end_count", end_cyc.size(), 1);
        enable = 1'b1;

        // Zeros then pseudo-random samples: never detect
        restart("rand");
        lfsr = 32'hACE1_1234;
        fill_zero(0, 200);
        for (int i = 200; i < 400; i++) begin
            lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
            smp[i] = lfsr;
        end
        drive_samples(400, 1);
        idle(6);
        check_metrics(400, "rand");
        chk("rand det_count", det_cyc.size(), 0);
        chk("rand active", ht_stf_active, 0);

        chk("det_end_overlap", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ans_ht_stf_detector.md
# ans_ht_stf_detector

Receive-side counterpart of `ans_ht_stf_generator`. It consumes a stream of 32-bit IQ samples, such as the generator's HT-STF output looped back or received baseband, and computes a sliding delay-16 autocorrelation against the window power. It declares HT-STF detection when the normalised correlation plateau persists, and signals the plateau end. Obfuscation coefficients alter only the STF subcarriers (multiples of 4), so 16-sample periodicity is preserved and detection needs no `obf_coeff` input.

## Interface
- `THRESH_SHIFT`, default 2: threshold is power − (power >>> THRESH_SHIFT), i.e. 0.75·power.
- `MIN_POWER`, default 256: window power below this never qualifies.
- `MIN_PLATEAU`, default 32: consecutive qualifying windows before detection.

Ports:
- `clk` in 1: single clock, 200 MHz.
- `rstn` in 1: asynchronous, active-low reset.
- `enable` in 1: low forces FILL and synchronously clears delay lines, accumulators and counters.
- `sample_in` in 32: [31:16] I signed, [15:0] Q signed.
- `sample_in_strobe` in 1: sample valid this cycle; may be asserted every cycle or gapped.
- `metric_valid` out 1: `corr_mag`/`corr_pwr` updated this cycle.
- `corr_mag` out 21: magnitude approximation of the correlation.
- `corr_pwr` out 21: window power.
- `ht_stf_active` out 1: level, high from detection until end.
- `ht_stf_detected` out 1: one-cycle pulse at detection.
- `ht_stf_end` out 1: one-cycle pulse when the plateau ends after detection.

## Operation
Arithmetic, per accepted sample s[n], with d = s[n−16] from a 16-deep sample delay line:
- re = I·Id + Q·Qd; im = Q·Id − I·Qd (33-bit signed).
- p = I² + Q² (33-bit unsigned).
- Each value is arithmetically shifted >>>16 and saturated to 17 bits.
- Three 16-deep product FIFOs feed running sums: acc += new − oldest, 21-bit, no overflow possible.
- corr_mag = max(|acc_re|,|acc_im|) + (min(|acc_re|,|acc_im|) >> 1).
- corr_pwr = acc_p.
- Qualify = (corr_pwr ≥ MIN_POWER) && (corr_mag > corr_pwr − (corr_pwr >>> THRESH_SHIFT)).

FSM, advancing only on pipeline-valid cycles:
- FILL: count accepted samples. After 32 samples (indices 0..31), the first metric is valid at index 31 → SEARCH. `metric_valid` is never asserted in FILL.
- SEARCH: qualify → PLATEAU with plat_cnt = 1.
- PLATEAU: qualify → plat_cnt++. When plat_cnt reaches MIN_PLATEAU, pulse `ht_stf_detected`, set `ht_stf_active`, and go to DETECTED. Not qualify → SEARCH, plat_cnt = 0, no pulse.
- DETECTED: stay while qualify. On the first non-qualifying window, pulse `ht_stf_end`, clear `ht_stf_active`, and go to SEARCH. The delay lines keep running; no re-fill.

Other rules:
- `enable` low in any state → FILL next cycle; outputs cleared, with no `ht_stf_end` pulse.
- plat_cnt saturates at MIN_PLATEAU.
- Detection re-arms only after an end.

## Timing
- Reset value of every output is 0. Delay lines, FIFOs and accumulators reset to 0; the FSM resets to FILL.
- Pipeline runs strobe to stage 1 (products) to stage 2 (accumulate) to stage 3 (magnitude, compare, FSM).
- `metric_valid`, `corr_*`, pulses and `ht_stf_active` change exactly 3 `clk` cycles after the strobe of the sample closing the window.
- A gapped strobe stalls nothing but inserts bubbles. Results depend only on sample order, not on strobe spacing.
- Continuous strobes give throughput of 1 sample/cycle.
- `rstn` asserted mid-plateau or while DETECTED clears everything immediately; no end pulse is generated.
- Detection and end never coincide in the same cycle.

## Test plan
- Constant I=0x2000, Q=0, 80 samples at strobe every cycle:
  - first `metric_valid` 3 cycles after sample 31;
  - `corr_mag` = `corr_pwr` = 0x4000 when the window is full;
  - `ht_stf_detected` 3 cycles after the strobe of sample 62;
  - then zeros follow, and `ht_stf_end` pulses no later than the window ending at index 96.
- Generator loopback: drive `ans_ht_stf_generator` output (obf_coeff = 0, then all-ones) into the block → exactly one detect pulse per burst in both cases.
- 200 zero samples, then 200 LFSR pseudo-random samples → `ht_stf_detected` never asserted; `metric_valid` pulses from index 31.
- Same constant stimulus with strobe every 3rd cycle → identical `corr_*` sequence and detection at sample 62 (3 cycles after its strobe).
- `rstn` pulsed low while PLATEAU at plat_cnt = 20 → all outputs 0 immediately, no end pulse; replay → detection again 63 samples after restart.
- Two 80-sample bursts separated by 64 zeros → detect/end/detect/end sequence; `enable` dropped inside the second burst → `ht_stf_active` falls with no end pulse.
